// File: rtl/seq_mem_pkg.sv
// Shared constants, FSM encoding and LFSR step for the sequence RAM and its users.
// Imported by the writer, the memory access mux and the player.
package seq_mem_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;
  localparam int SYM_W  = 2;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] SEED      = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wr_state_e;

  // Galois right-shift step; a non-zero state never maps to zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/seq_lfsr.sv
// Free-running 16-bit Galois LFSR, one step per cycle out of reset.
// No handshake: the state output is always valid.
module seq_lfsr #(
  parameter logic [15:0] SEED = seq_mem_pkg::SEED
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] state
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = seq_mem_pkg::lfsr_next(lfsr_q);
  assign state  = lfsr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/sequence_writer.sv
// Appends one pseudo-random symbol per command to the sequence RAM; done one cycle after the write.
// Latency 2 cycles with grant held; a WRITE stalls with stable address/data while grant is low.
module sequence_writer
  import seq_mem_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              init,
  input  logic              extend,
  input  logic              grant,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              full,
  output logic [ADDR_W:0]   seq_len,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren
);

  wr_state_e         state_q;
  logic [ADDR_W:0]   seq_len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              done_q;
  logic              ovf_q;
  logic [15:0]       lfsr;
  logic [DATA_W-1:0] sym_word;

  seq_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .state (lfsr)
  );

  assign sym_word    = {{(DATA_W-SYM_W){1'b0}}, lfsr[SYM_W-1:0]};
  assign full        = (seq_len_q == (ADDR_W+1)'(DEPTH));
  assign busy        = (state_q != IDLE);
  assign mem_wren    = (state_q == WRITE) && grant;
  assign done        = done_q;
  assign overflow    = ovf_q;
  assign seq_len     = seq_len_q;
  assign mem_address = addr_q;
  assign mem_data    = data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      seq_len_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // init has priority and suppresses any overflow from a simultaneous extend.
          if (init) begin
            seq_len_q <= '0;
            addr_q    <= '0;
            data_q    <= sym_word;
            state_q   <= WRITE;
          end else if (extend) begin
            if (full) begin
              ovf_q <= 1'b1;
            end else begin
              addr_q  <= seq_len_q[ADDR_W-1:0];
              data_q  <= sym_word;
              state_q <= WRITE;
            end
          end
        end
        WRITE: begin
          if (grant) begin
            seq_len_q <= seq_len_q + 1'b1;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
